irig_encoder: RTL and testbench
===============================

IRIG_ENCODER -- requirements
Module: irig_encoder

Interface
REQ-001 Parameter CLKS_PER_MS, default 10000, clk cycles per millisecond (>=2).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 enable  input  1  arms the encoder; 0 forces IDLE at the next frame boundary.
REQ-005 pps_in  input  1  one-cycle pulse marking the on-time second.
REQ-006 time_valid  input  1  time fields below are valid.
REQ-007 time_ready  output  1  shadow register empty; transfer occurs when time_valid && time_ready.
REQ-008 sec/min/hour/day/year  input  6/6/5/9/7  binary time for the next frame.
REQ-009 sbs  input  17  straight-binary seconds of day.
REQ-010 irig_out  output  1  DC-level IRIG-B pulse-width-coded output.
REQ-011 frame_start  output  1  one-cycle pulse on the first cycle of bit 0.
REQ-012 bit_idx  output  7  index (0..99) of the bit being sent.
REQ-013 busy  output  1  frame in progress.
REQ-014 pps_err  output  1  one-cycle pulse: pps_in ignored mid-frame.
REQ-015 missed  output  1  one-cycle pulse, coincident with frame_start: no new time loaded; previous frame data repeated.
REQ-016 field_err  output  1  one-cycle pulse: transfer rejected as out of range.

Function
REQ-017 States: IDLE, ARMED, RUN; ARMED is entered from IDLE when enable=1.
REQ-018 ARMED + pps_in at cycle T -> RUN; irig_out rises and frame_start=1 at T+1.
REQ-019 Bit period 10 ms; irig_out high for 8 ms (marker), 5 ms (one), or 2 ms (zero), then low for the rest of the period.
REQ-020 Markers at bits 0, 9, 19, 29 ... 99; every other unassigned bit is zero.
REQ-021 Fields are BCD, LSB first:
  - seconds: units 1-4, tens 6-8
  - minutes: units 10-13, tens 15-17
  - hours: units 20-23, tens 25-26
  - day: units 30-33, tens 35-38, hundreds 40-41
  - year: units 50-53, tens 55-58
  - control bits 60-79: zero
REQ-022 Binary-to-BCD conversion happens when a transfer is accepted; time_ready deasserts for exactly one cycle, then reasserts.
REQ-023 Range limits: sec>59, min>59, hour>23, day 0 or >366, year>99, or sbs>86399 -> transfer consumed, shadow unchanged, field_err=1.
REQ-024 At frame start, a full shadow moves to the frame register and the shadow empties; an empty shadow -> frame register retained and missed=1.
REQ-025 Frame length is exactly 1000*CLKS_PER_MS cycles.
REQ-026 pps_in in the last frame cycle, or in ARMED, starts the next frame back-to-back; pps_in elsewhere in RUN is ignored and pps_err=1.
REQ-027 End of frame: enable=1 -> ARMED; enable=0 -> IDLE; irig_out=0 in ARMED and IDLE.
REQ-028 busy=1 only in RUN; bit_idx holds 0 outside RUN.
REQ-029 All counters are exact-width and wrap only at their terminal values (ms 0..CLKS_PER_MS-1, ms-in-bit 0..9, bit 0..99).

Reset
REQ-030 Reset values: state IDLE, irig_out=0, time_ready=1, frame_start=0, busy=0, bit_idx=0, pps_err=0, missed=0, field_err=0.
REQ-031 Shadow and frame registers clear to all-zero data.
REQ-032 rst mid-frame drops irig_out to 0 on the next edge; no partial bit completes.

Configuration
REQ-033 Macro IRIG_SBS_EN defined: sbs encoded LSB first, bits 0-8 on frame bits 80-88 and bits 9-16 on frame bits 90-97.
REQ-034 Macro IRIG_SBS_EN undefined: sbs ignored, never range-checked; bits 80-97 (non-marker) are zero.

Verification
REQ-035 Bench uses CLKS_PER_MS=4; all scenarios below assume that value.
REQ-036 Load 12:34:56, day 123, year 24, pps -> bit 0 high 32 cycles; bit 1 (sec units LSB=0) high 8; bit 2 high 20; bit 5 high 8; bit 9 high 32.
REQ-037 Two pps 4000 cycles apart, no reload on the second -> second frame starts back-to-back with missed=1 and identical data.
REQ-038 pps_in at bit 40 -> pps_err=1 for one cycle; waveform unchanged.
REQ-039 Transfer with sec=60 -> field_err=1; next frame carries prior seconds.
REQ-040 With IRIG_SBS_EN, sbs=86399 -> bits 80-88 high 20 cycles on value 1, 8 on 0, matching 0x1517F LSB first; without it, all 8.
REQ-041 rst asserted at bit 50 -> next cycle irig_out=0, busy=0, bit_idx=0, time_ready=1.

Source files
------------

// File: rtl/irig_if.sv
// irig_if: time-of-day transfer channel (valid/ready) feeding the IRIG encoder shadow register.
interface irig_if;
    logic        time_valid;
    logic        time_ready;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic [8:0]  day;
    logic [6:0]  year;
    logic [16:0] sbs;

    modport master (output time_valid, sec, min, hour, day, year, sbs, input time_ready);
    modport slave  (input  time_valid, sec, min, hour, day, year, sbs, output time_ready);
endinterface

// File: rtl/irig_encoder.sv
// irig_encoder: DC-level IRIG-B pulse-width frame generator with a validated BCD shadow register.
// Define IRIG_SBS_EN to also encode straight-binary seconds on frame bits 80-88 and 90-97.
module irig_encoder #(
    parameter int unsigned CLKS_PER_MS = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pps_in,
    irig_if.slave      tif,
    output logic       irig_out,
    output logic       frame_start,
    output logic [6:0] bit_idx,
    output logic       busy,
    output logic       pps_err,
    output logic       missed,
    output logic       field_err
);
    localparam int unsigned     MS_W    = $clog2(CLKS_PER_MS);
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(CLKS_PER_MS - 1);
    localparam logic [99:0]     MARKERS = {{9{10'b1000000000}}, 10'b1000000001};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]      state, state_d;
    logic [MS_W-1:0] ms_cnt, ms_d;
    logic [3:0]      mib, mib_d;
    logic [6:0]      bit_cnt, bit_d;
    logic [99:0]     frame_q, frame_d, shadow_q, shadow_d, enc;
    logic            full_q, full_d;
    logic            accept, in_range, last_cycle, start;
    logic            irig_d, ready_d, pps_err_d, missed_d, field_err_d;
    logic [3:0]      width_d;

    assign accept     = tif.time_valid && tif.time_ready;
    assign last_cycle = (state == S_RUN) && (bit_cnt == 7'd99) && (mib == 4'd9) && (ms_cnt == MS_LAST);

`ifdef IRIG_SBS_EN
    assign in_range = (tif.sec <= 6'd59) && (tif.min <= 6'd59) && (tif.hour <= 5'd23) &&
                      (tif.day != 9'd0) && (tif.day <= 9'd366) && (tif.year <= 7'd99) &&
                      (tif.sbs <= 17'd86399);
`else
    logic sbs_unused;
    assign sbs_unused = ^tif.sbs;
    assign in_range = (tif.sec <= 6'd59) && (tif.min <= 6'd59) && (tif.hour <= 5'd23) &&
                      (tif.day != 9'd0) && (tif.day <= 9'd366) && (tif.year <= 7'd99);
`endif

    // Binary-to-BCD frame image, LSB of each digit on the lowest frame bit
    always_comb begin
        enc          = '0;
        enc[4:1]     = 4'(tif.sec % 6'd10);
        enc[8:6]     = 3'(tif.sec / 6'd10);
        enc[13:10]   = 4'(tif.min % 6'd10);
        enc[17:15]   = 3'(tif.min / 6'd10);
        enc[23:20]   = 4'(tif.hour % 5'd10);
        enc[26:25]   = 2'(tif.hour / 5'd10);
        enc[33:30]   = 4'(tif.day % 9'd10);
        enc[38:35]   = 4'((tif.day / 9'd10) % 9'd10);
        enc[41:40]   = 2'(tif.day / 9'd100);
        enc[53:50]   = 4'(tif.year % 7'd10);
        enc[58:55]   = 4'(tif.year / 7'd10);
`ifdef IRIG_SBS_EN
        enc[88:80]   = tif.sbs[8:0];
        enc[97:90]   = tif.sbs[16:9];
`endif
    end

    // Next-state, counter, shadow and output logic
    always_comb begin
        state_d     = state;
        ms_d        = ms_cnt;
        mib_d       = mib;
        bit_d       = bit_cnt;
        frame_d     = frame_q;
        shadow_d    = shadow_q;
        full_d      = full_q;
        start       = 1'b0;
        pps_err_d   = 1'b0;
        missed_d    = 1'b0;
        field_err_d = 1'b0;
        ready_d     = 1'b1;

        case (state)
            S_IDLE: if (enable) state_d = S_ARMED;
            S_ARMED: begin
                if (!enable)     state_d = S_IDLE;
                else if (pps_in) start   = 1'b1;
            end
            S_RUN: begin
                if (last_cycle) begin
                    if (pps_in && enable) start   = 1'b1;
                    else                  state_d = enable ? S_ARMED : S_IDLE;
                end else begin
                    pps_err_d = pps_in;
                    if (ms_cnt == MS_LAST) begin
                        ms_d = '0;
                        if (mib == 4'd9) begin
                            mib_d = '0;
                            bit_d = bit_cnt + 7'd1;
                        end else begin
                            mib_d = mib + 4'd1;
                        end
                    end else begin
                        ms_d = ms_cnt + MS_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d = S_RUN;
            if (full_q) begin
                frame_d = shadow_q;
                full_d  = 1'b0;
            end else begin
                missed_d = 1'b1;
            end
        end

        if (start || (state_d != S_RUN)) begin
            ms_d  = '0;
            mib_d = '0;
            bit_d = '0;
        end

        // A transfer arriving on a frame-start edge refills the shadow just emptied
        if (accept) begin
            ready_d = 1'b0;
            if (in_range) begin
                shadow_d = enc;
                full_d   = 1'b1;
            end else begin
                field_err_d = 1'b1;
            end
        end

        width_d = MARKERS[bit_d] ? 4'd8 : (frame_d[bit_d] ? 4'd5 : 4'd2);
        irig_d  = (state_d == S_RUN) && (mib_d < width_d);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ms_cnt         <= '0;
            mib            <= '0;
            bit_cnt        <= '0;
            frame_q        <= '0;
            shadow_q       <= '0;
            full_q         <= 1'b0;
            irig_out       <= 1'b0;
            frame_start    <= 1'b0;
            bit_idx        <= '0;
            busy           <= 1'b0;
            pps_err        <= 1'b0;
            missed         <= 1'b0;
            field_err      <= 1'b0;
            tif.time_ready <= 1'b1;
        end else begin
            ms_cnt         <= ms_d;
            mib            <= mib_d;
            bit_cnt        <= bit_d;
            frame_q        <= frame_d;
            shadow_q       <= shadow_d;
            full_q         <= full_d;
            irig_out       <= irig_d;
            frame_start    <= start;
            bit_idx        <= (state_d == S_RUN) ? bit_d : 7'd0;
            busy           <= (state_d == S_RUN);
            pps_err        <= pps_err_d;
            missed         <= missed_d;
            field_err      <= field_err_d;
            tif.time_ready <= ready_d;
        end
    end
endmodule

// File: tb/tb_irig_encoder.sv
// tb_irig_encoder: scoreboard bench for irig_encoder at CLKS_PER_MS=4 (40-cycle bits, 4000-cycle frames).
module tb_irig_encoder;
    localparam int BIT_CYC = 40;
    localparam int K_PPS   = 1;
    localparam int K_FIELD = 2;
`ifdef IRIG_SBS_EN
    localparam logic [16:0] SBS_A_EXP = 17'h1517F;
`else
    localparam logic [16:0] SBS_A_EXP = 17'h0;
`endif

    typedef struct packed {
        logic            miss;
        logic [7:0]      nb;
        logic [99:0][5:0] w;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst, enable, pps_in;
    logic       irig_out, frame_start, busy, pps_err, missed, field_err;
    logic [6:0] bit_idx;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    frame_t     exp_q[$];
    int         ev_q[$];

    irig_if tif();

    irig_encoder #(.CLKS_PER_MS(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .pps_in(pps_in), .tif(tif),
        .irig_out(irig_out), .frame_start(frame_start), .bit_idx(bit_idx),
        .busy(busy), .pps_err(pps_err), .missed(missed), .field_err(field_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected high time per bit from hand-supplied BCD digits
    function automatic frame_t make_exp(input logic miss, input logic [7:0] nb,
            input logic [3:0] su, input logic [2:0] st, input logic [3:0] mu, input logic [2:0] mt,
            input logic [3:0] hu, input logic [1:0] ht, input logic [3:0] du, input logic [3:0] dt,
            input logic [1:0] dh, input logic [3:0] yu, input logic [3:0] yt, input logic [16:0] sb);
        frame_t      f;
        logic [99:0] one;
        one        = '0;
        one[4:1]   = su;  one[8:6]   = st;
        one[13:10] = mu;  one[17:15] = mt;
        one[23:20] = hu;  one[26:25] = ht;
        one[33:30] = du;  one[38:35] = dt;  one[41:40] = dh;
        one[53:50] = yu;  one[58:55] = yt;
        one[88:80] = sb[8:0];
        one[97:90] = sb[16:9];
        f.miss = miss;
        f.nb   = nb;
        for (int b = 0; b < 100; b++)
            f.w[b] = (b == 0 || b % 10 == 9) ? 6'd32 : (one[b] ? 6'd20 : 6'd8);
        return f;
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pps_pulse();
        pps_in = 1'b1;
        @(negedge clk);
        pps_in = 1'b0;
    endtask

    task automatic transfer(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h,
                            input logic [8:0] d, input logic [6:0] y, input logic [16:0] sb);
        int guard;
        guard = 0;
        @(negedge clk);
        while (tif.time_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_xfer", 32'(tif.time_ready), 32'd1);
        tif.sec = s; tif.min = m; tif.hour = h; tif.day = d; tif.year = y; tif.sbs = sb;
        tif.time_valid = 1'b1;
        @(negedge clk);
        tif.time_valid = 1'b0;
        check("ready_drop", 32'(tif.time_ready), 32'd0);
        @(negedge clk);
        check("ready_back", 32'(tif.time_ready), 32'd1);
    endtask

    task automatic pop_ev(input int kind, input string name);
        if (ev_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_unexpected: pulse seen, none expected (cycle %0d)", name, cyc);
        end else begin
            check(name, 32'(ev_q.pop_front()), 32'(kind));
        end
    endtask

    // Pulse-event monitor
    initial begin : ev_mon
        forever begin
            @(negedge clk);
            if (pps_err === 1'b1)   pop_ev(K_PPS, "pps_err");
            if (field_err === 1'b1) pop_ev(K_FIELD, "field_err");
        end
    end

    // Frame monitor: measures high time of every bit of each started frame
    initial begin : frame_mon
        frame_t e;
        int     hi;
        forever begin
            if (frame_start !== 1'b1) begin
                @(negedge clk);
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL frame_unexpected: frame_start with no frame expected (cycle %0d)", cyc);
                @(negedge clk);
            end else begin
                e = exp_q.pop_front();
                check("missed", 32'(missed), 32'(e.miss));
                for (int b = 0; b < int'(e.nb); b++) begin
                    check($sformatf("bit_idx_b%0d", b), 32'(bit_idx), 32'(b));
                    hi = 0;
                    for (int c = 0; c < BIT_CYC; c++) begin
                        if (b == 0 && c == 1) check("frame_start_len", 32'(frame_start), 32'd0);
                        if (irig_out === 1'b1) hi++;
                        @(negedge clk);
                    end
                    check($sformatf("width_b%0d", b), 32'(hi), 32'(e.w[b]));
                end
            end
        end
    end

    initial begin : stim
        int c0, c1, c2, c3;
        rst = 1'b1; enable = 1'b0; pps_in = 1'b0;
        tif.time_valid = 1'b0; tif.sec = '0; tif.min = '0; tif.hour = '0;
        tif.day = '0; tif.year = '0; tif.sbs = '0;
        repeat (3) @(negedge clk);
        check("rst_irig_out", 32'(irig_out), 32'd0);
        check("rst_time_ready", 32'(tif.time_ready), 32'd1);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bit_idx", 32'(bit_idx), 32'd0);
        check("rst_pps_err", 32'(pps_err), 32'd0);
        check("rst_missed", 32'(missed), 32'd0);
        check("rst_field_err", 32'(field_err), 32'd0);
        rst = 1'b0;
        enable = 1'b1;

        // Frame 1: 12:34:56, day 123, year 24, sbs 86399
        transfer(6'd56, 6'd34, 5'd12, 9'd123, 7'd24, 17'd86399);
        c0 = cyc + 5;
        wait_until(c0);
        exp_q.push_back(make_exp(1'b0, 8'd100, 4'd6, 3'd5, 4'd4, 3'd3, 4'd2, 2'd1,
                                 4'd3, 4'd2, 2'd1, 4'd4, 4'd2, SBS_A_EXP));
        pps_pulse();
        check("start_frame_start", 32'(frame_start), 32'd1);
        check("start_irig_out", 32'(irig_out), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_bit_idx", 32'(bit_idx), 32'd0);

        // Stray pps inside bit 40, then an out-of-range seconds transfer
        wait_until(c0 + 1605);
        ev_q.push_back(K_PPS);
        pps_pulse();
        wait_until(c0 + 2000);
        ev_q.push_back(K_FIELD);
        transfer(6'd60, 6'd2, 5'd1, 9'd4, 7'd5, 17'd0);

        // Frame 2: back-to-back pps, nothing new loaded -> repeat frame 1 with missed
        c1 = c0 + 4000;
        wait_until(c1);
        exp_q.push_back(make_exp(1'b1, 8'd100, 4'd6, 3'd5, 4'd4, 3'd3, 4'd2, 2'd1,
                                 4'd3, 4'd2, 2'd1, 4'd4, 4'd2, SBS_A_EXP));
        pps_pulse();
        wait_until(c1 + 500);
        transfer(6'd7, 6'd59, 5'd23, 9'd366, 7'd99, 17'd0);
        wait_until(c1 + 4000);
        check("last_bit_idx", 32'(bit_idx), 32'd99);
        check("last_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("armed_busy", 32'(busy), 32'd0);
        check("armed_irig_out", 32'(irig_out), 32'd0);
        check("armed_bit_idx", 32'(bit_idx), 32'd0);

        // Frame 3: 23:59:07 day 366 year 99 from ARMED; reset during bit 50
        c2 = c1 + 4050;
        wait_until(c2);
        exp_q.push_back(make_exp(1'b0, 8'd50, 4'd7, 3'd0, 4'd9, 3'd5, 4'd3, 2'd2,
                                 4'd6, 4'd6, 2'd3, 4'd9, 4'd9, 17'd0));
        pps_pulse();
        wait_until(c2 + 2010);
        check("pre_rst_bit_idx", 32'(bit_idx), 32'd50);
        check("pre_rst_irig_out", 32'(irig_out), 32'd1);
        rst = 1'b1;
        tif.sec = 6'd1; tif.min = 6'd1; tif.hour = 5'd1; tif.day = 9'd1; tif.year = 7'd1; tif.sbs = 17'd0;
        tif.time_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tif.time_valid = 1'b0;
        check("mid_rst_irig_out", 32'(irig_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_bit_idx", 32'(bit_idx), 32'd0);
        check("mid_rst_time_ready", 32'(tif.time_ready), 32'd1);
        check("mid_rst_frame_start", 32'(frame_start), 32'd0);

        // Frame 4: cleared registers, nothing loaded -> all-zero data with missed
        c3 = cyc + 10;
        wait_until(c3);
        exp_q.push_back(make_exp(1'b1, 8'd100, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0, 2'd0,
                                 4'd0, 4'd0, 2'd0, 4'd0, 4'd0, 17'd0));
        pps_pulse();
        wait_until(c3 + 4020);

        check("frames_pending", 32'(exp_q.size()), 32'd0);
        check("events_pending", 32'(ev_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
